thirty_two_register_write_decoder_bank: RTL and testbench

Write side of the 32-entry register file. Decodes a 5-bit write address into a one-hot enable, holds 32 registers of `BITS` bits, and exposes all of them as a packed array. The read-side 32:1 select muxes consume that array. A per-register busy scoreboard, set by the issue stage and cleared by write-back, feeds hazard detection.

---
 rtl/thirty_two_register_write_decoder_bank_pkg.sv | 17 +
 rtl/thirty_two_register_write_decoder_bank_five_bits_to_thirty_two_one_hot_decoder.sv | 19 +
 rtl/thirty_two_register_write_decoder_bank.sv | 81 ++++++++
 tb/tb_thirty_two_register_write_decoder_bank.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/thirty_two_register_write_decoder_bank_pkg.sv
// Shared definitions for the register-file write side.
// Contents: register count and address width, the hard-wired zero register,
// the address and mask types, and the mask that excludes register 0.
package thirty_two_register_write_decoder_bank_pkg;

  localparam int REG_COUNT     = 32;
  localparam int REG_ADDR_BITS = 5;

  typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]     reg_mask_t;

  localparam reg_addr_t ZERO_REGISTER = 5'd0;

  // Clears the zero-register bit from any per-register mask.
  localparam reg_mask_t NONZERO_MASK = ~(reg_mask_t'(1) << ZERO_REGISTER);

endpackage

// File: rtl/thirty_two_register_write_decoder_bank_five_bits_to_thirty_two_one_hot_decoder.sv
// 5-to-32 one-hot decoder with enable.
// Ports:
//   addr_i    - register address to decode
//   en_i      - when 0 the output is all zeros
//   one_hot_o - one bit set at position addr_i when enabled
module five_bits_to_thirty_two_one_hot_decoder
  import thirty_two_register_write_decoder_bank_pkg::*;
(
  input  reg_addr_t addr_i,
  input  logic      en_i,
  output reg_mask_t one_hot_o
);

  always_comb begin
    one_hot_o = '0;
    if (en_i) one_hot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/thirty_two_register_write_decoder_bank.sv
// Write side of the 32-entry register file plus the busy scoreboard.
// Ports:
//   CLOCK, RESET_N          - clock, async active-low reset
//   WRITE_ENABLE/ADDRESS/DATA - write-back request
//   RESERVE_ENABLE/ADDRESS  - issue-stage destination claim
//   REGISTERS               - all register contents, index 0 reads zero
//   BUSY                    - per-register scoreboard, bit 0 always 0
//   WRITE_ONE_HOT           - combinational gated decode of the write address
//   ORPHAN_WRITE            - sticky: a write landed on a non-busy register
module thirty_two_register_write_decoder_bank
  import thirty_two_register_write_decoder_bank_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic                           CLOCK,
  input  logic                           RESET_N,
  input  logic                           WRITE_ENABLE,
  input  logic [REG_ADDR_BITS-1:0]       WRITE_ADDRESS,
  input  logic [BITS-1:0]                WRITE_DATA,
  input  logic                           RESERVE_ENABLE,
  input  logic [REG_ADDR_BITS-1:0]       RESERVE_ADDRESS,
  output logic [REG_COUNT-1:0][BITS-1:0] REGISTERS,
  output logic [REG_COUNT-1:0]           BUSY,
  output logic [REG_COUNT-1:0]           WRITE_ONE_HOT,
  output logic                           ORPHAN_WRITE
);

  reg_mask_t wr_raw, rsv_raw;
  reg_mask_t wr_hit, rsv_hit;

  five_bits_to_thirty_two_one_hot_decoder u_wr_dec (
    .addr_i    (WRITE_ADDRESS),
    .en_i      (WRITE_ENABLE),
    .one_hot_o (wr_raw)
  );

  five_bits_to_thirty_two_one_hot_decoder u_rsv_dec (
    .addr_i    (RESERVE_ADDRESS),
    .en_i      (RESERVE_ENABLE),
    .one_hot_o (rsv_raw)
  );

  // Register 0 is hard-wired, so neither path may ever hit it.
  assign wr_hit        = wr_raw  & NONZERO_MASK;
  assign rsv_hit       = rsv_raw & NONZERO_MASK;
  assign WRITE_ONE_HOT = wr_hit;

  // Data registers: only 1..31 are stored.
  logic [REG_COUNT-1:1][BITS-1:0] regs_q;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N)       regs_q[i] <= '0;
      else if (wr_hit[i]) regs_q[i] <= WRITE_DATA;
    end
  end

  assign REGISTERS = {regs_q, {BITS{1'b0}}};

  // Scoreboard: a reserve in the same cycle as the write-back belongs to a
  // younger instruction, so the set term dominates the clear term.
  reg_mask_t busy_q, busy_d;
  logic      orphan_q, orphan_d;

  assign busy_d   = (rsv_hit | (busy_q & ~wr_hit)) & NONZERO_MASK;
  assign orphan_d = orphan_q | (|(wr_hit & ~busy_q));

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      orphan_q <= orphan_d;
    end
  end

  assign BUSY         = busy_q;
  assign ORPHAN_WRITE = orphan_q;

endmodule

// File: tb/tb_thirty_two_register_write_decoder_bank.sv
module tb_thirty_two_register_write_decoder_bank;

  logic              CLOCK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              WRITE_ENABLE = 1'b0;
  logic [4:0]        WRITE_ADDRESS = '0;
  logic [31:0]       WRITE_DATA = '0;
  logic              RESERVE_ENABLE = 1'b0;
  logic [4:0]        RESERVE_ADDRESS = '0;
  logic [31:0][31:0] REGISTERS;
  logic [31:0]       BUSY;
  logic [31:0]       WRITE_ONE_HOT;
  logic              ORPHAN_WRITE;

  thirty_two_register_write_decoder_bank #(.BITS(32)) dut (
    .CLOCK           (CLOCK),
    .RESET_N         (RESET_N),
    .WRITE_ENABLE    (WRITE_ENABLE),
    .WRITE_ADDRESS   (WRITE_ADDRESS),
    .WRITE_DATA      (WRITE_DATA),
    .RESERVE_ENABLE  (RESERVE_ENABLE),
    .RESERVE_ADDRESS (RESERVE_ADDRESS),
    .REGISTERS       (REGISTERS),
    .BUSY            (BUSY),
    .WRITE_ONE_HOT   (WRITE_ONE_HOT),
    .ORPHAN_WRITE    (ORPHAN_WRITE)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    string       name;
    logic [31:0] busy;
    logic        orph;
    int          ridx;
    logic [31:0] rval;
    logic [31:0] oh;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: after every rising edge the state for the vector issued in the
  // preceding half-cycle is visible; inputs are still held so the
  // combinational decode is checked in the same place.
  always @(posedge CLOCK) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, " busy"},   BUSY,                  e.busy);
      check({e.name, " orphan"}, {31'd0, ORPHAN_WRITE}, {31'd0, e.orph});
      check({e.name, " reg"},    REGISTERS[e.ridx],     e.rval);
      check({e.name, " onehot"}, WRITE_ONE_HOT,         e.oh);
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra);
    @(negedge CLOCK);
    WRITE_ENABLE    = we;
    WRITE_ADDRESS   = wa;
    WRITE_DATA      = wd;
    RESERVE_ENABLE  = re;
    RESERVE_ADDRESS = ra;
  endtask

  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic re, input logic [4:0] ra, input string nm,
                      input logic [31:0] ebusy, input logic eorph, input int ridx,
                      input logic [31:0] rval, input logic [31:0] eoh);
    exp_t e;
    drive(we, wa, wd, re, ra);
    e.name = nm; e.busy = ebusy; e.orph = eorph; e.ridx = ridx; e.rval = rval; e.oh = eoh;
    sb.push_back(e);
  endtask

  task automatic mid_reset_check(input string nm);
    drive(0, 0, 0, 0, 0);
    #2 RESET_N = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) check($sformatf("%s reg%0d", nm, i), REGISTERS[i], 32'd0);
    check({nm, " busy"},   BUSY,                  32'd0);
    check({nm, " orphan"}, {31'd0, ORPHAN_WRITE}, 32'd0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [31:0] m;
    // Random traffic, then an asynchronous reset between edges.
    @(negedge CLOCK);
    RESET_N = 1'b1;
    for (int k = 0; k < 6; k++)
      drive(1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b1, 5'($urandom_range(0, 31)));
    mid_reset_check("rst_random");

    // Basic reserve then write-back.
    step(0, 0, 0, 1, 5, "rsv5", 32'h0000_0020, 0, 5, 32'd0, 32'd0);
    step(1, 5, 32'hDEAD_BEEF, 0, 0, "wr5", 32'd0, 0, 5, 32'hDEAD_BEEF, 32'h0000_0020);
    // Zero register: write and reserve r0 together.
    step(1, 0, 32'hFFFF_FFFF, 1, 0, "r0", 32'd0, 0, 0, 32'd0, 32'd0);
    // Same-address collision: reserve wins, data still written.
    step(0, 0, 0, 1, 7, "rsv7", 32'h0000_0080, 0, 7, 32'd0, 32'd0);
    step(1, 7, 32'h1234_5678, 1, 7, "coll7", 32'h0000_0080, 0, 7, 32'h1234_5678, 32'h0000_0080);
    // Different addresses in the same cycle.
    step(1, 7, 32'h0000_00AA, 1, 3, "wr7rsv3", 32'h0000_0008, 0, 7, 32'h0000_00AA, 32'h0000_0080);
    // Re-reserve of an already busy register.
    step(0, 0, 0, 1, 3, "rersv3", 32'h0000_0008, 0, 3, 32'd0, 32'd0);
    step(1, 3, 32'h0000_0033, 0, 0, "wr3", 32'd0, 0, 3, 32'h0000_0033, 32'h0000_0008);
    // Orphan write and its stickiness.
    step(1, 9, 32'h0000_0001, 0, 0, "orph9", 32'd0, 1, 9, 32'h0000_0001, 32'h0000_0200);
    for (int k = 0; k < 10; k++)
      step(0, 0, 0, 0, 0, $sformatf("idle%0d", k), 32'd0, 1, 9, 32'h0000_0001, 32'd0);
    mid_reset_check("rst_orphan");

    // Full sweep: reserve 1..31, then write back 31..1 with the index.
    m = 32'd0;
    for (int i = 1; i < 32; i++) begin
      m[i] = 1'b1;
      step(0, 0, 0, 1, 5'(i), $sformatf("sweep_rsv%0d", i), m, 0, i, 32'd0, 32'd0);
    end
    check("sweep_full_busy_const", m, 32'hFFFF_FFFE);
    for (int i = 31; i >= 1; i--) begin
      logic [31:0] oh;
      m[i] = 1'b0;
      oh = 32'd0;
      oh[i] = 1'b1;
      step(1, 5'(i), 32'(i), 0, 0, $sformatf("sweep_wr%0d", i), m, 0, i, 32'(i), oh);
    end
    drive(0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge CLOCK);
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    @(negedge CLOCK);
    for (int i = 0; i < 32; i++) check($sformatf("final reg%0d", i), REGISTERS[i], 32'(i));
    check("final busy", BUSY, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
